// File: rtl/div_pkg.sv
// Shared constants and FSM state type for the 16x8 restoring divider.
package div_pkg;

  localparam int DEF_DIVIDEND_W = 16;
  localparam int DEF_DIVISOR_W  = 8;
  localparam int DEF_CNT_W      = $clog2(DEF_DIVIDEND_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int DIVISOR_W = 8
) (
  input  logic [DIVISOR_W:0]   r,
  input  logic                 dvd_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   r_next,
  output logic                 q_bit
);

  logic [DIVISOR_W:0] t;
  logic               ge;

  // r[DIVISOR_W] set means the shifted value overflowed t, so it certainly exceeds the divisor.
  always_comb begin
    t      = {r[DIVISOR_W-1:0], dvd_bit};
    ge     = r[DIVISOR_W] | (t >= {1'b0, divisor});
    q_bit  = ge;
    r_next = ge ? (t - {1'b0, divisor}) : t;
  end

endmodule

// File: rtl/restoring_divider16x8.sv
// Sequential unsigned restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Optional RESTORING_DIV_EARLY_EXIT_EN: dividend < divisor completes without running the steps.
//
// state | meaning
// IDLE  | in_ready=1, waiting for operands
// RUN   | one restoring step per cycle, count down to 1
// DONE  | result held, out_valid=1 until out_ready
module restoring_divider16x8
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CW = $clog2(DIVIDEND_W + 1);

`ifdef RESTORING_DIV_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  div_state_e            state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DIVISOR_W:0]    r_q, r_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  dbz_q, dbz_d;
  logic                  hold_q, hold_d;

  logic [DIVISOR_W:0]    r_next;
  logic                  q_bit;

  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .r       (r_q),
    .dvd_bit (dvd_q[DIVIDEND_W-1]),
    .divisor (dvs_q),
    .r_next  (r_next),
    .q_bit   (q_bit)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    r_d       = r_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    hold_d    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Short paths spend one settle cycle in DONE so out_valid appears one edge after accept.
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend[DIVISOR_W-1:0];
            dbz_d   = 1'b1;
            hold_d  = 1'b1;
            state_d = DONE;
          end else if (EARLY_EXIT && (dividend < DIVIDEND_W'(divisor))) begin
            quot_d  = '0;
            rem_d   = dividend[DIVISOR_W-1:0];
            dbz_d   = 1'b0;
            hold_d  = 1'b1;
            state_d = DONE;
          end else begin
            dvd_d   = dividend;
            dvs_d   = divisor;
            r_d     = '0;
            quot_d  = '0;
            dbz_d   = 1'b0;
            count_d = CW'(DIVIDEND_W);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d     = r_next;
        dvd_d   = {dvd_q[DIVIDEND_W-2:0], 1'b0};
        quot_d  = {quot_q[DIVIDEND_W-2:0], q_bit};
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          rem_d   = r_next[DIVISOR_W-1:0];
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = ~hold_q;
        if (~hold_q && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      r_q     <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      r_q     <= r_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      hold_q  <= hold_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider16x8.sv
// Bench for restoring_divider16x8: vector table, corner sequences and random ops vs. an arithmetic model.
module tb_restoring_divider16x8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  restoring_divider16x8 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_lat(input logic [15:0] a, input logic [7:0] b);
    if (b == 0) return 1;
`ifdef RESTORING_DIV_EARLY_EXIT_EN
    if (a < {8'd0, b}) return 1;
`endif
    return 16;
  endfunction

  task automatic start_op(input logic [15:0] a, input logic [7:0] b);
    int w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic check_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] q, input logic [7:0] r, input logic dbz);
    int lat;
    start_op(a, b);
    wait_done(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat(a, b)));
    chk({tag, "_q"}, 32'(quotient), 32'(q));
    chk({tag, "_r"}, 32'(remainder), 32'(r));
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(dbz));
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    logic [15:0] ra, mq;
    logic [7:0]  rb, mr;

    vecs[0] = '{16'd150,   8'd10,  16'd15,    8'd0,   1'b0};
    vecs[1] = '{16'd65025, 8'd255, 16'd255,   8'd0,   1'b0};
    vecs[2] = '{16'd300,   8'd7,   16'd42,    8'd6,   1'b0};
    vecs[3] = '{16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0};
    vecs[4] = '{16'd1234,  8'd0,   16'hFFFF,  8'hD2,  1'b1};
    vecs[5] = '{16'd5,     8'd10,  16'd0,     8'd5,   1'b0};
    vecs[6] = '{16'd0,     8'd3,   16'd0,     8'd0,   1'b0};
    vecs[7] = '{16'd255,   8'd16,  16'd15,    8'd15,  1'b0};
    vecs[8] = '{16'd65535, 8'd255, 16'd257,   8'd0,   1'b0};
    vecs[9] = '{16'd1000,  8'd3,   16'd333,   8'd1,   1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);

    // Backpressure: result held while out_ready=0, competing operands ignored.
    out_ready = 1'b0;
    start_op(16'd300, 8'd7);
    wait_done(lat);
    chk("bp_lat", 32'(lat), 32'd16);
    in_valid = 1'b1; dividend = 16'd2000; divisor = 8'd20;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_q", 32'(quotient), 32'd42);
      chk("bp_r", 32'(remainder), 32'd6);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_hs_out_valid", 32'(out_valid), 32'd0);
    chk("bp_hs_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_accept_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_done(lat);
    chk("bp2_lat", 32'(lat), 32'd16);
    chk("bp2_q", 32'(quotient), 32'd100);
    chk("bp2_r", 32'(remainder), 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of RUN discards the operation.
    start_op(16'd2500, 8'd50);
    repeat (7) begin
      @(posedge clk); #1;
    end
    chk("mid_run_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_q", 32'(quotient), 32'd0);
    chk("mrst_r", 32'(remainder), 32'd0);
    chk("mrst_dbz", 32'(div_by_zero), 32'd0);
    check_op("post_rst", 16'd2000, 8'd20, 16'd100, 8'd0, 1'b0);

    // Random operands against plain integer division.
    for (int n = 0; n < 60; n++) begin
      ra = 16'($urandom);
      rb = (n % 15 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if (n % 7 == 3) ra = 16'($urandom_range(0, 300));
      if (rb == 0) begin
        mq = 16'hFFFF;
        mr = ra[7:0];
      end else begin
        mq = ra / {8'd0, rb};
        mr = 8'(ra % {8'd0, rb});
      end
      check_op("rnd", ra, rb, mq, mr, rb == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/restoring_divider16x8.md
# restoring_divider16x8

Sequential unsigned 16-by-8 restoring divider, the inverse operation of the team's combinational 8x8 multiplier. It accepts a dividend/divisor pair over a valid/ready handshake and produces one quotient bit per cycle, MSB first. It returns quotient, remainder and a divide-by-zero flag over a second valid/ready handshake. It sits in the arithmetic datapath next to the multiplier and is used to verify and invert products, e.g. 65025 / 255 = 255.

## Interface
- DIVIDEND_W, 16, dividend and quotient width
- DIVISOR_W, 8, divisor and remainder width
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  divider idle, can accept operands
- dividend  input  DIVIDEND_W  unsigned dividend
- divisor  input  DIVISOR_W  unsigned divisor
- out_valid  output  1  result valid, held until accepted
- out_ready  input  1  consumer accepts result
- quotient  output  DIVIDEND_W  unsigned quotient
- remainder  output  DIVISOR_W  unsigned remainder
- div_by_zero  output  1  divisor was zero

## Operation
- FSM states:
  - IDLE: in_ready=1. Accept on in_valid & in_ready.
    - divisor==0 -> DONE
    - otherwise load operands, count=DIVIDEND_W -> RUN
  - RUN: one restoring step per cycle. count decrements; at count==1 the step completes -> DONE.
  - DONE: out_valid=1; outputs stable. Exit to IDLE on out_valid & out_ready.
- Restoring step:
  - Partial remainder r is DIVISOR_W+1 bits.
  - t = {r[DIVISOR_W-1:0], next dividend bit (MSB first)}.
  - If t >= {1'b0, divisor}: r = t - divisor, quotient bit = 1. Else r = t, quotient bit = 0.
  - Quotient shifts in from the LSB.
- Final remainder = r[DIVISOR_W-1:0], always < divisor.
- Divide by zero: quotient = all ones (16'hFFFF), remainder = dividend[DIVISOR_W-1:0], div_by_zero=1.
- div_by_zero=0 for every non-zero divisor.
- Operands are sampled only on the accept edge; input changes afterwards are ignored.
- in_ready is 0 in RUN and DONE. A result handshake and a new operand accept never happen in the same cycle.

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, quotient=0, remainder=0, div_by_zero=0, count=0.
- Normal latency: with the accept at edge k, out_valid rises after edge k+16 (16 RUN cycles). Minimum issue interval is 18 cycles (accept, 16 RUN, DONE handshake).
- Divide-by-zero latency: out_valid rises after edge k+1.
- Backpressure: DONE holds indefinitely while out_ready=0, with all outputs stable.
- in_ready rises the cycle after the result handshake.
- quotient/remainder may change during RUN. They are only meaningful while out_valid=1.
- rst in any state, including mid-RUN or DONE: the operation is aborted and the result discarded. All outputs take reset values after that edge, and state is IDLE on the next cycle.

## Configuration
- RESTORING_DIV_EARLY_EXIT_EN:
  - Defined: in IDLE, when divisor!=0 and dividend < divisor, the accept goes directly to DONE with quotient=0, remainder=dividend[DIVISOR_W-1:0], div_by_zero=0. out_valid rises after edge k+1.
  - Undefined: every non-zero-divisor operation takes the full 16 RUN cycles. Results are identical either way; only latency differs.

## Structure
- Shared package div_pkg:
  - DIVIDEND_W / DIVISOR_W defaults
  - FSM state enum (IDLE, RUN, DONE)
  - count width constant $clog2(DIVIDEND_W+1)
- One sub-module, div_step: combinational single restoring step.
  - Inputs: r, dividend bit, divisor.
  - Outputs: next r, quotient bit.
  - Instantiated once in the top.
- The top holds the FSM, counter, operand/quotient shift registers and output registers.

## Test plan
- 150 / 10: accept at edge k -> out_valid after edge k+16, quotient=15, remainder=0, div_by_zero=0.
- 65025 / 255 -> 255 r 0. 300 / 7 -> 42 r 6. 65535 / 1 -> 65535 r 0.
- 1234 / 0 -> after 1 cycle: quotient=16'hFFFF, remainder=8'hD2, div_by_zero=1.
- 5 / 10:
  - With RESTORING_DIV_EARLY_EXIT_EN -> 0 r 5 after 1 cycle.
  - Without it -> 0 r 5 after 16 cycles.
- Backpressure:
  - out_ready=0 for 20 cycles -> out_valid and outputs held stable, in_ready=0.
  - Second in_valid meanwhile is not accepted.
  - After the handshake, the next operand is accepted one cycle later.
- rst asserted at RUN cycle 8 of 2500 / 50 -> outputs zeroed next cycle, in_ready=1.
- New 2000 / 20 after that -> 100 r 0 with normal latency.
